// File: rtl/rr_mux_reg.sv
// ---------------------------------------------------------------------------
// rr_mux_reg
//
// Purpose:
//   N-channel, WIDTH-bit multiplexer with a valid/ready handshake on every
//   input and on the output. The winning channel is chosen either explicitly
//   (sel) or by round-robin arbitration among the valid channels. The chosen
//   word is registered (1-cycle latency) together with its channel index.
//   The output stage is a single-stage pipe that can drain and reload in the
//   same cycle, so it sustains one word per clock.
//
// Optional feature (macro RR_MUX_PKT_LOCK_EN):
//   Adds the in_last port and a two-state IDLE/LOCKED FSM. Once a
//   multi-beat packet starts on a channel, the grant is pinned to that
//   channel until the beat flagged with in_last has been transferred.
//   Without the macro every transfer is a single-beat packet.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = explicit select via sel, 1 = round-robin
//   sel        explicit channel select (ignored when mode=1)
//   in_data    channel k occupies bits [k*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_last    per-channel end-of-packet (RR_MUX_PKT_LOCK_EN only)
//   in_ready   per-channel ready, one-hot or zero
//   out_data   registered selected word
//   out_chan   index of the channel that supplied out_data
//   out_valid  output word valid
//   out_ready  consumer accepts output
//
// Parameters:
//   WIDTH     data width per channel
//   CHANNELS  number of input channels (2..16)
//   SEL_W     index width, must equal $clog2(CHANNELS)
// ---------------------------------------------------------------------------
module rr_mux_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [CHANNELS-1:0]         in_valid,
`ifdef RR_MUX_PKT_LOCK_EN
    input  logic [CHANNELS-1:0]         in_last,
`endif
    output logic [CHANNELS-1:0]         in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_chan,
    output logic                        out_valid,
    input  logic                        out_ready
);

    // Channel count expressed at index width + 1, used for modulo wrap.
    localparam logic [SEL_W:0]   CH_W    = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    // Output / arbitration state
    logic [WIDTH-1:0]      r_out_data;
    logic [SEL_W-1:0]      r_out_chan;
    logic                  r_out_valid;
    logic [SEL_W-1:0]      r_rr_ptr;

    // Combinational arbitration results
    logic [2*CHANNELS-1:0] w_rot_valid;
    logic                  w_rr_vld;
    logic [SEL_W-1:0]      w_rr_grant;
    logic                  w_sel_vld;
    logic                  w_grant_vld;
    logic [SEL_W-1:0]      w_grant;
    logic [WIDTH-1:0]      w_grant_data;
    logic                  w_last;
    logic                  w_load;
    logic                  w_xfer;

    // -----------------------------------------------------------------------
    // Round-robin search: rotate the valid vector so that bit 0 is the
    // channel at rr_ptr, then take the lowest set bit and map it back to an
    // absolute channel index with a modulo-CHANNELS add.
    // -----------------------------------------------------------------------
    assign w_rot_valid = {in_valid, in_valid} >> r_rr_ptr;

    always_comb begin
        logic [SEL_W:0] w_sum;
        // NOTE: every combinationally assigned signal gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        w_rr_vld   = 1'b0;
        w_rr_grant = '0;
        w_sum      = '0;
        // Scanning downward lets the lowest offset win.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_rot_valid[i]) begin
                w_rr_vld = 1'b1;
                w_sum    = {1'b0, r_rr_ptr} + (SEL_W+1)'(i);
                if (w_sum >= CH_W) begin
                    w_sum = w_sum - CH_W;
                end
                w_rr_grant = SEL_W'(w_sum);
            end
        end
    end

    // Explicit select: a sel value with no matching channel never grants.
    always_comb begin
        w_sel_vld = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_vld = in_valid[k];
            end
        end
    end

    // Gated by rst_n so no producer sees ready while the block is in reset.
    assign w_load = rst_n && (!r_out_valid || out_ready);

`ifdef RR_MUX_PKT_LOCK_EN
    // -----------------------------------------------------------------------
    // Packet lock FSM
    // -----------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t      r_state;
    lock_state_t      w_state_nxt;
    logic [SEL_W-1:0] r_lock_chan;
    logic             w_lock_vld;

    always_comb begin
        w_lock_vld = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_lock_chan == SEL_W'(k)) begin
                w_lock_vld = in_valid[k];
            end
        end
    end

    // While locked the grant is pinned to the packet's channel, ignoring
    // mode, sel and every other valid.
    always_comb begin
        if (r_state == ST_LOCKED) begin
            w_grant_vld = w_lock_vld;
            w_grant     = r_lock_chan;
        end else if (mode) begin
            w_grant_vld = w_rr_vld;
            w_grant     = w_rr_grant;
        end else begin
            w_grant_vld = w_sel_vld;
            w_grant     = sel;
        end
    end

    always_comb begin
        w_last = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_grant == SEL_W'(k)) begin
                w_last = in_last[k];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_xfer && !w_last) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_xfer &&  w_last) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lock_chan <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_xfer && !w_last) begin
                r_lock_chan <= w_grant;
            end
        end
    end
`else
    always_comb begin
        if (mode) begin
            w_grant_vld = w_rr_vld;
            w_grant     = w_rr_grant;
        end else begin
            w_grant_vld = w_sel_vld;
            w_grant     = sel;
        end
    end

    // Every transfer is a complete single-beat packet.
    assign w_last = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Data select and handshake
    // -----------------------------------------------------------------------
    always_comb begin
        w_grant_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_grant == SEL_W'(k)) begin
                w_grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            in_ready[k] = w_load && w_grant_vld && (w_grant == SEL_W'(k));
        end
    end

    // A grant always implies in_valid[grant], so grant && load is a transfer.
    assign w_xfer = w_grant_vld && w_load;

    // -----------------------------------------------------------------------
    // Output register and round-robin pointer
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                // Also covers drain-and-reload in one cycle: no bubble.
                r_out_data  <= w_grant_data;
                r_out_chan  <= w_grant;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                // Drain only; data and channel keep their last values.
                r_out_valid <= 1'b0;
            end

            // Pointer moves only on the final beat of a round-robin transfer.
            if (w_xfer && mode && w_last) begin
                r_rr_ptr <= (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_reg
//
// Directed testbench for rr_mux_reg (WIDTH=8, CHANNELS=8, SEL_W=3).
// Channel k always carries 8'h10+k. Inputs change #1 after a rising edge and
// outputs are sampled at that same point, away from the active edge.
// With RR_MUX_PKT_LOCK_EN defined the packet-lock scenario is also run.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_mux_reg;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 8;
    localparam int SEL_W    = 3;

    logic                      clk;
    logic                      rst_n;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
`ifdef RR_MUX_PKT_LOCK_EN
    logic [CHANNELS-1:0]       in_last;
`endif
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    int n_vec = 0;
    int n_err = 0;

    rr_mux_reg #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef RR_MUX_PKT_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", out_data); end
        n_vec++; if (out_chan !== 3'd0) begin n_err++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
        n_vec++; if (in_ready !== 8'h00) begin n_err++; $display("FAIL reset_in_ready: got %b want 00000000", in_ready); end
    endtask

    task automatic test_explicit();
        mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        n_vec++; if (in_ready !== 8'b0010_0000) begin n_err++; $display("FAIL expl_ready_pre: got %b want 00100000", in_ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            n_vec++; if (out_data !== 8'h15) begin n_err++; $display("FAIL expl_data[%0d]: got %h want 15", c, out_data); end
            n_vec++; if (out_chan !== 3'd5) begin n_err++; $display("FAIL expl_chan[%0d]: got %0d want 5", c, out_chan); end
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL expl_valid[%0d]: got %b want 1", c, out_valid); end
            n_vec++; if (in_ready !== 8'b0010_0000) begin n_err++; $display("FAIL expl_ready[%0d]: got %b want 00100000", c, in_ready); end
        end
        // Selected channel not valid: no grant, output drains and holds data.
        in_valid = 8'b1101_1111;
        #1;
        n_vec++; if (in_ready !== 8'h00) begin n_err++; $display("FAIL expl_nogrant_ready: got %b want 00000000", in_ready); end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h15) begin n_err++; $display("FAIL drain_data_hold: got %h want 15", out_data); end
        n_vec++; if (out_chan !== 3'd5) begin n_err++; $display("FAIL drain_chan_hold: got %0d want 5", out_chan); end
    endtask

    task automatic test_round_robin();
        logic [SEL_W-1:0] exp_chan;
        logic [WIDTH-1:0] exp_data;
        // Explicit-mode transfers left rr_ptr at 0.
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            exp_chan = SEL_W'(c % 8);
            exp_data = 8'h10 + WIDTH'(c % 8);
            n_vec++; if (out_chan !== exp_chan) begin n_err++; $display("FAIL rr_chan[%0d]: got %0d want %0d", c, out_chan, exp_chan); end
            n_vec++; if (out_data !== exp_data) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", c, out_data, exp_data); end
        end
    endtask

    task automatic test_reset_mid_stream();
        // Output is valid (last round-robin beat); reset off the clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_data: got %h want 00", out_data); end
        n_vec++; if (out_chan !== 3'd0) begin n_err++; $display("FAIL rst_mid_chan: got %0d want 0", out_chan); end
        n_vec++; if (in_ready !== 8'h00) begin n_err++; $display("FAIL rst_mid_ready: got %b want 00000000", in_ready); end
        #1;
        rst_n = 1'b1;
        step();
        n_vec++; if (out_chan !== 3'd0) begin n_err++; $display("FAIL rst_restart_chan: got %0d want 0", out_chan); end
        n_vec++; if (out_data !== 8'h10) begin n_err++; $display("FAIL rst_restart_data: got %h want 10", out_data); end
    endtask

    task automatic test_sparse_rr();
        logic [SEL_W-1:0] exp_seq [4];
        exp_seq = '{3'd1, 3'd4, 3'd7, 3'd1};
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        mode = 1'b1; in_valid = 8'b1001_0010; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_vec++; if (out_chan !== exp_seq[c]) begin n_err++; $display("FAIL sparse_chan[%0d]: got %0d want %0d", c, out_chan, exp_seq[c]); end
        end
        // rr_ptr is now 2; an explicit transfer must not disturb it.
        mode = 1'b0; sel = 3'd0; in_valid = 8'hFF;
        step();
        n_vec++; if (out_chan !== 3'd0) begin n_err++; $display("FAIL modesw_expl_chan: got %0d want 0", out_chan); end
        mode = 1'b1;
        step();
        n_vec++; if (out_chan !== 3'd2) begin n_err++; $display("FAIL modesw_rr_chan: got %0d want 2", out_chan); end
    endtask

    task automatic test_back_to_back();
        mode = 1'b0; sel = 3'd3; in_valid = 8'hFF; out_ready = 1'b1;
        step();
        n_vec++; if (out_data !== 8'h13) begin n_err++; $display("FAIL bp_fill_data: got %h want 13", out_data); end
        out_ready = 1'b0; sel = 3'd6;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (in_ready !== 8'h00) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 00000000", c, in_ready); end
            step();
            n_vec++; if (out_data !== 8'h13) begin n_err++; $display("FAIL bp_hold_data[%0d]: got %h want 13", c, out_data); end
            n_vec++; if (out_chan !== 3'd3) begin n_err++; $display("FAIL bp_hold_chan[%0d]: got %0d want 3", c, out_chan); end
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 8'b0100_0000) begin n_err++; $display("FAIL bp_release_ready: got %b want 01000000", in_ready); end
        step();
        n_vec++; if (out_data !== 8'h16) begin n_err++; $display("FAIL bp_reload_data: got %h want 16", out_data); end
        n_vec++; if (out_chan !== 3'd6) begin n_err++; $display("FAIL bp_reload_chan: got %0d want 6", out_chan); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_reload_valid: got %b want 1", out_valid); end
    endtask

`ifdef RR_MUX_PKT_LOCK_EN
    task automatic test_pkt_lock();
        logic [SEL_W-1:0] exp_seq [4];
        exp_seq = '{3'd2, 3'd2, 3'd2, 3'd3};
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        mode = 1'b1; in_valid = 8'b0000_1100; in_last = 8'h00; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            // Channel 2 flags its third beat; channel 3 is a single beat.
            if (c == 2) in_last = 8'b0000_0100;
            if (c == 3) in_last = 8'b0000_1000;
            step();
            n_vec++; if (out_chan !== exp_seq[c]) begin n_err++; $display("FAIL lock_chan[%0d]: got %0d want %0d", c, out_chan, exp_seq[c]); end
        end
        in_last = 8'hFF;
    endtask
`endif

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = 8'hFF; out_ready = 1'b1;
`ifdef RR_MUX_PKT_LOCK_EN
        in_last = 8'hFF;
`endif
        for (int k = 0; k < CHANNELS; k++) begin
            in_data[k*WIDTH +: WIDTH] = 8'h10 + WIDTH'(k);
        end

        test_reset();
        test_explicit();
        test_round_robin();
        test_reset_mid_stream();
        test_sparse_rr();
        test_back_to_back();
`ifdef RR_MUX_PKT_LOCK_EN
        test_pkt_lock();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
